npu_cmd_decoder: RTL

Parametrised NPU bus decoder. It classifies each bus access into a memory-region access or an operation command, and registers memory accesses as a one-cycle pulse with the region-relative offset. Operation-register writes are pushed into a command FIFO, which the NPU controller drains through a valid/ready handshake. Unmapped and overflow conditions raise sticky error flags. The block sits between the NPU slave port and `npu_controller`.

---
 rtl/pkg_memorymap.sv | 17 +
 rtl/pkg_npu_cmd.sv | 22 ++
 rtl/npu_cmd_fifo.sv | 51 +++++
 rtl/npu_cmd_decoder.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/pkg_memorymap.sv
// NPU slave-port memory map: half-open [Start, End) byte ranges and the
// base of the word-spaced operation-register block.
package pkg_memorymap;

    localparam logic [31:0] NPU_IMEM_Start = 32'h0001_0000;
    localparam logic [31:0] NPU_IMEM_End   = 32'h0001_1000;
    localparam logic [31:0] NPU_WMEM_Start = 32'h0002_0000;
    localparam logic [31:0] NPU_WMEM_End   = 32'h0002_4000;
    localparam logic [31:0] NPU_BMEM_Start = 32'h0003_0000;
    localparam logic [31:0] NPU_BMEM_End   = 32'h0003_0400;
    localparam logic [31:0] NPU_OMEM_Start = 32'h0004_0000;
    localparam logic [31:0] NPU_OMEM_End   = 32'h0004_1000;
    localparam logic [31:0] NPU_PARA_Start = 32'h0005_0000;
    localparam logic [31:0] NPU_PARA_End   = 32'h0005_0100;
    localparam logic [31:0] NPU_OP_Start   = 32'h0006_0000;

endpackage

// File: rtl/pkg_npu_cmd.sv
// Region codes, error-flag bit positions and the command entry layout
// shared by the NPU command decoder and the controller.
package pkg_npu_cmd;

    localparam logic [3:0] TYPE_IMEM = 4'b1000;
    localparam logic [3:0] TYPE_WMEM = 4'b1001;
    localparam logic [3:0] TYPE_BMEM = 4'b1010;
    localparam logic [3:0] TYPE_OMEM = 4'b1011;
    localparam logic [3:0] TYPE_PARA = 4'b1100;

    localparam int ERR_UNMAPPED = 0;
    localparam int ERR_OVERFLOW = 1;

    localparam int CMD_OP_WIDTH  = 4;
    localparam int CMD_ARG_WIDTH = 8;

    typedef struct packed {
        logic [CMD_OP_WIDTH-1:0]  op;
        logic [CMD_ARG_WIDTH-1:0] arg;
    } npu_cmd_t;

endpackage

// File: rtl/npu_cmd_fifo.sv
// Synchronous FIFO with exact occupancy count; a push while full is accepted
// only when a pop happens in the same cycle. Head data reads as zero when empty.
module npu_cmd_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_ni,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the count gates what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/npu_cmd_decoder.sv
// NPU bus decoder: registers memory-region accesses as one-cycle pulses and
// queues operation-register writes as commands for npu_controller.
module npu_cmd_decoder
    import pkg_memorymap::*;
    import pkg_npu_cmd::*;
#(
    parameter int DWidth     = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int OP_WIDTH   = 4,
    parameter int NUM_OPS    = 4,
    parameter int CMD_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_ni,
    input  logic                           cen_i,
    input  logic                           wen_i,
    input  logic [ADDR_WIDTH-1:0]          addr_i,
    input  logic [DWidth-1:0]              wdata_i,
    output logic                           acc_valid_o,
    output logic [OP_WIDTH-1:0]            acc_type_o,
    output logic [ADDR_WIDTH-1:0]          acc_offset_o,
    output logic                           acc_we_o,
    output logic [DWidth-1:0]              acc_wdata_o,
    output logic                           cmd_valid_o,
    input  logic                           cmd_ready_i,
    output logic [OP_WIDTH-1:0]            cmd_op_o,
    output logic [DWidth-1:0]              cmd_arg_o,
    output logic                           cmd_full_o,
    output logic [$clog2(CMD_DEPTH+1)-1:0] cmd_count_o,
    output logic [1:0]                     err_o,
    input  logic                           err_clr_i
);

    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef struct packed {
        logic [OP_WIDTH-1:0] op;
        logic [DWidth-1:0]   arg;
    } cmd_t;

    localparam addr_t IMEM_S = ADDR_WIDTH'(NPU_IMEM_Start);
    localparam addr_t IMEM_E = ADDR_WIDTH'(NPU_IMEM_End);
    localparam addr_t WMEM_S = ADDR_WIDTH'(NPU_WMEM_Start);
    localparam addr_t WMEM_E = ADDR_WIDTH'(NPU_WMEM_End);
    localparam addr_t BMEM_S = ADDR_WIDTH'(NPU_BMEM_Start);
    localparam addr_t BMEM_E = ADDR_WIDTH'(NPU_BMEM_End);
    localparam addr_t OMEM_S = ADDR_WIDTH'(NPU_OMEM_Start);
    localparam addr_t OMEM_E = ADDR_WIDTH'(NPU_OMEM_End);
    localparam addr_t PARA_S = ADDR_WIDTH'(NPU_PARA_Start);
    localparam addr_t PARA_E = ADDR_WIDTH'(NPU_PARA_End);
    localparam addr_t OP_S   = ADDR_WIDTH'(NPU_OP_Start);

    function automatic logic in_range(input addr_t a, input addr_t s, input addr_t e);
        return (a >= s) && (a < e);
    endfunction

    logic                mem_hit;
    logic                op_hit;
    logic                unmapped;
    logic [OP_WIDTH-1:0] region;
    addr_t               base;
    addr_t               op_idx;
    logic                push;
    logic                pop;
    logic                overflow;
    logic                fifo_empty;
    logic [1:0]          err_set;
    cmd_t                push_cmd;
    cmd_t                head_cmd;

    assign op_idx = (addr_i - OP_S) >> 2;

    always_comb begin
        // NOTE: every decode output gets a default first so no path infers a latch.
        mem_hit  = 1'b0;
        op_hit   = 1'b0;
        unmapped = 1'b0;
        region   = '0;
        base     = '0;
        if (in_range(addr_i, IMEM_S, IMEM_E)) begin
            mem_hit = 1'b1; region = OP_WIDTH'(TYPE_IMEM); base = IMEM_S;
        end else if (in_range(addr_i, WMEM_S, WMEM_E)) begin
            mem_hit = 1'b1; region = OP_WIDTH'(TYPE_WMEM); base = WMEM_S;
        end else if (in_range(addr_i, BMEM_S, BMEM_E)) begin
            mem_hit = 1'b1; region = OP_WIDTH'(TYPE_BMEM); base = BMEM_S;
        end else if (in_range(addr_i, OMEM_S, OMEM_E)) begin
            mem_hit = 1'b1; region = OP_WIDTH'(TYPE_OMEM); base = OMEM_S;
        end else if (in_range(addr_i, PARA_S, PARA_E)) begin
            mem_hit = 1'b1; region = OP_WIDTH'(TYPE_PARA); base = PARA_S;
        end else if (addr_i >= OP_S && addr_i[1:0] == 2'b00 && op_idx < ADDR_WIDTH'(NUM_OPS)) begin
            op_hit = 1'b1;
        end else begin
            unmapped = 1'b1;
        end
    end

    // Valid op reads fall through here: neither a push nor an error.
    assign push     = cen_i & wen_i & op_hit;
    assign pop      = cmd_valid_o & cmd_ready_i;
    assign overflow = push & cmd_full_o & ~pop;
    assign push_cmd = '{op: op_idx[OP_WIDTH-1:0], arg: wdata_i};

    always_comb begin
        err_set               = '0;
        err_set[ERR_UNMAPPED] = cen_i & unmapped;
        err_set[ERR_OVERFLOW] = overflow;
    end

    npu_cmd_fifo #(
        .WIDTH ($bits(cmd_t)),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_ni(rst_ni),
        .push  (push),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head_cmd),
        .full  (cmd_full_o),
        .empty (fifo_empty),
        .count (cmd_count_o)
    );

    assign cmd_valid_o = ~fifo_empty;
    assign cmd_op_o    = head_cmd.op;
    assign cmd_arg_o   = head_cmd.arg;

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            acc_valid_o  <= 1'b0;
            acc_type_o   <= '0;
            acc_offset_o <= '0;
            acc_we_o     <= 1'b0;
            acc_wdata_o  <= '0;
            err_o        <= '0;
        end else begin
            acc_valid_o <= cen_i & mem_hit;
            if (cen_i & mem_hit) begin
                acc_type_o   <= region;
                acc_offset_o <= addr_i - base;
                acc_we_o     <= wen_i;
                acc_wdata_o  <= wdata_i;
            end
            // A same-cycle error event survives a clear.
            err_o <= err_clr_i ? err_set : (err_o | err_set);
        end
    end

endmodule
